// File: rtl/flipper_axi_pkg.sv
// Shared AXI read-side constants and the read-arbiter state encoding for the
// Flipper memory interface blocks.
package flipper_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

endpackage

// File: rtl/flipper_rr_picker.sv
// Combinational round-robin find-first: lowest index at or after ptr
// (modulo NUM_REQ) whose valid bit is set.
module flipper_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] j;

  // Scan from the farthest candidate back toward ptr so the nearest one wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flipper_mem_read_arbiter.sv
// Round-robin share of the single AXI Interface A read master among NUM_REQ
// fetch engines; one burst in flight, R channel steered to the granted engine.
module flipper_mem_read_arbiter
  import flipper_axi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][3:0]          req_len,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [127:0]                     rsp_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic                             rsp_last,
  output logic                             rsp_err,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [ADDR_W-1:0]                araddrm_a,
  output logic [1:0]                       arburstm_a,
  output logic [3:0]                       arlenm_a,
  output logic [2:0]                       arsizem_a,
  output logic                             arvalidm_a,
  input  logic                             arreadym_a,
  input  logic [127:0]                     rdatam_a,
  input  logic [1:0]                       rrespm_a,
  input  logic                             rlastm_a,
  input  logic                             rvalidm_a,
  output logic                             rreadym_a
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [3:0]         beat_cnt;
  logic               len_mismatch;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               in_data;
  logic               r_hs;

  flipper_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign in_data    = (state == ARB_DATA);
  assign req_ready  = (state == ARB_IDLE) ? pick_onehot : '0;
  assign arburstm_a = AXI_BURST_INCR;
  assign arsizem_a  = AXI_SIZE_16B;

  // R channel is a pure pass-through to the granted requester.
  assign rsp_data  = rdatam_a;
  assign rsp_last  = rlastm_a;
  assign rsp_err   = (rrespm_a != AXI_RESP_OKAY);
  assign rreadym_a = in_data & rsp_ready[grant];
  assign r_hs      = rvalidm_a & rreadym_a;

  always_comb begin
    rsp_valid = '0;
    if (in_data) rsp_valid[grant] = rvalidm_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      beat_cnt     <= '0;
      len_mismatch <= 1'b0;
      araddrm_a    <= '0;
      arlenm_a     <= '0;
      arvalidm_a   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            araddrm_a  <= {req_addr[pick_idx][ADDR_W-1:4], 4'b0000};
            arlenm_a   <= req_len[pick_idx];
            beat_cnt   <= req_len[pick_idx];
            grant      <= pick_idx;
            arvalidm_a <= 1'b1;
            state      <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (arreadym_a) begin
            arvalidm_a <= 1'b0;
            state      <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt - 4'd1;
            // Sticky debug flag; the burst still ends on rlastm_a.
            if (rlastm_a != (beat_cnt == 4'd0)) len_mismatch <= 1'b1;
            if (rlastm_a) begin
              state  <= ARB_IDLE;
              rr_ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flipper_mem_read_arbiter.sv
// Directed bench for flipper_mem_read_arbiter: transaction-level model checked
// every cycle, plus literal expectations per scenario.
module tb_flipper_mem_read_arbiter;
  import flipper_axi_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]        req_valid, req_ready, rsp_valid;
  logic [N-1:0]        rsp_ready = '1;
  logic [N-1:0][31:0]  req_addr = '0;
  logic [N-1:0][3:0]   req_len = '0;
  logic [127:0]        rsp_data;
  logic [127:0]        rdatam_a = '0;
  logic                rsp_last, rsp_err;
  logic [31:0]         araddrm_a;
  logic [1:0]          arburstm_a;
  logic [3:0]          arlenm_a;
  logic [2:0]          arsizem_a;
  logic                arvalidm_a, rreadym_a;
  logic                arreadym_a = 1'b0;
  logic [1:0]          rrespm_a = 2'b00;
  logic                rlastm_a = 1'b0;
  logic                rvalidm_a = 1'b0;

  flipper_mem_read_arbiter #(.NUM_REQ(N), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .araddrm_a(araddrm_a), .arburstm_a(arburstm_a), .arlenm_a(arlenm_a), .arsizem_a(arsizem_a),
    .arvalidm_a(arvalidm_a), .arreadym_a(arreadym_a),
    .rdatam_a(rdatam_a), .rrespm_a(rrespm_a), .rlastm_a(rlastm_a), .rvalidm_a(rvalidm_a),
    .rreadym_a(rreadym_a)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // requester side: each requester holds valid while it has requests left
  int req_cnt [N];
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < N; i++) req_valid[i] = (req_cnt[i] != 0);
  end

  // transaction-level model: who owns the port, is the AR still pending
  int          m_owner = -1;
  bit          m_ar = 1'b0;
  int          m_ptr = 0;
  int          m_beats = 0;
  bit          m_mism = 1'b0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_len = '0;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  typedef struct {
    int           who;
    logic [127:0] data;
    bit           last;
    bit           err;
  } beat_t;
  beat_t beat_q[$];
  int    grant_q[$];

  // AXI slave state
  int          ar_delay = 0, ar_wait = 0, err_beat = -1, early_last = 99, beat = 0;
  bit          serving = 1'b0, toggle_en = 1'b0;
  logic [31:0] ar_addr_cap = '0;
  logic [3:0]  ar_len_cap = '0;
  bit          s_ar_hs = 1'b0, s_r_hs = 1'b0, s_rst = 1'b0;
  logic [N-1:0] s_acc = '0;

  // compare against the model, log transactions, advance the model
  always @(negedge clk) begin
    int g;
    bit in_data;
    logic [N-1:0] exp_rv;
    g = rr_pick(req_valid, m_ptr);
    in_data = (m_owner >= 0) && !m_ar;
    exp_rv = '0;
    if (in_data && rvalidm_a) exp_rv[m_owner] = 1'b1;
    chk("req_ready", req_ready, (m_owner < 0 && g >= 0) ? (128'(1) << g) : 128'(0));
    chk("arvalid", arvalidm_a, (m_owner >= 0) && m_ar);
    if (m_owner >= 0 && m_ar) begin
      chk("araddr", araddrm_a, m_addr);
      chk("arlen", arlenm_a, m_len);
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rready", rreadym_a, in_data ? rsp_ready[m_owner] : 1'b0);
    chk("rsp_data", rsp_data, rdatam_a);
    chk("rsp_last", rsp_last, rlastm_a);
    chk("rsp_err", rsp_err, rrespm_a != 2'b00);
    chk("arburst", arburstm_a, 2'b01);
    chk("arsize", arsizem_a, 3'b100);
    chk("len_mismatch", dut.len_mismatch, m_mism);

    if (req_ready != '0) grant_q.push_back($clog2(req_ready));
    if (rvalidm_a && rreadym_a && rsp_valid != '0)
      beat_q.push_back('{$clog2(rsp_valid), rsp_data, rsp_last, rsp_err});

    if (reset) begin
      m_owner = -1; m_ar = 1'b0; m_ptr = 0; m_beats = 0; m_mism = 1'b0;
    end else if (m_owner < 0) begin
      if (g >= 0) begin
        m_owner = g; m_ar = 1'b1;
        m_addr = req_addr[g] & ~32'hF;
        m_len = req_len[g];
        m_beats = int'(req_len[g]);
      end
    end else if (m_ar) begin
      if (arreadym_a) m_ar = 1'b0;
    end else if (rvalidm_a && rsp_ready[m_owner]) begin
      if (rlastm_a != (m_beats == 0)) m_mism = 1'b1;
      m_beats--;
      if (rlastm_a) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end

    s_ar_hs = arvalidm_a && arreadym_a;
    s_r_hs  = rvalidm_a && rreadym_a;
    s_acc   = req_ready;
    s_rst   = reset;
  end

  // AXI slave and requester bookkeeping, acting just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (s_rst) begin
      arreadym_a = 1'b0; serving = 1'b0; ar_wait = 0; beat = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (s_acc[i] && req_cnt[i] > 0) req_cnt[i]--;
      if (s_r_hs) begin
        if (rlastm_a) serving = 1'b0;
        else beat++;
      end
      if (s_ar_hs) begin
        arreadym_a = 1'b0; ar_wait = 0; serving = 1'b1; beat = 0;
        ar_addr_cap = araddrm_a; ar_len_cap = arlenm_a;
      end else if (arvalidm_a) begin
        if (ar_wait >= ar_delay) arreadym_a = 1'b1;
        else ar_wait++;
      end
      if (toggle_en) rsp_ready[2] = ~rsp_ready[2];
    end
    rvalidm_a = serving;
    rlastm_a  = serving && (beat == int'(ar_len_cap) || beat == early_last);
    rrespm_a  = (serving && beat == err_beat) ? 2'b10 : 2'b00;
    rdatam_a  = serving ? {ar_addr_cap, 64'h5a5a_0000_0000_a5a5, 32'(beat)} : 128'(0);
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit pend;
    n = 0;
    repeat (2) cyc();
    forever begin
      pend = 1'b0;
      for (int i = 0; i < N; i++) if (req_cnt[i] != 0) pend = 1'b1;
      if (!pend && m_owner < 0 && !serving) break;
      if (n >= 400) begin
        vectors++; miscompares++;
        $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        break;
      end
      cyc();
      n++;
    end
    cyc();
  endtask

  task automatic clear_logs;
    beat_q.delete();
    grant_q.delete();
  endtask

  initial begin
    int exp_g[$];
    int n;
    for (int i = 0; i < N; i++) req_cnt[i] = 0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // single request, ARREADY delayed
    clear_logs();
    req_addr[0] = 32'h0000_1234; req_len[0] = 4'd3; ar_delay = 2;
    req_cnt[0] = 1;
    wait_done("t1");
    chk("t1_araddr", ar_addr_cap, 32'h0000_1230);
    chk("t1_arlen", ar_len_cap, 4'd3);
    chk("t1_nbeats", beat_q.size(), 4);
    foreach (beat_q[i]) begin
      chk("t1_who", beat_q[i].who, 0);
      chk("t1_beatno", beat_q[i].data[31:0], i);
      chk("t1_last", beat_q[i].last, i == 3);
    end
    chk("t1_state_idle", dut.state, ARB_IDLE);
    chk("t1_arvalid_low", arvalidm_a, 1'b0);

    // all four valid out of reset, len 0, requester 0 asks twice
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h1000 * (i + 1) + 32'h10 * i;
      req_len[i] = 4'd0;
    end
    req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
    ar_delay = 0;
    repeat (2) cyc();
    clear_logs();
    reset = 1'b0;
    wait_done("t2");
    exp_g = '{0, 1, 2, 3, 0};
    chk("t2_ngrants", grant_q.size(), 5);
    foreach (grant_q[i]) if (i < 5) chk("t2_grant_order", grant_q[i], exp_g[i]);
    chk("t2_nbeats", beat_q.size(), 5);
    chk("t2_rr_ptr", dut.rr_ptr, 1);

    // backpressure toggling on requester 2
    clear_logs();
    req_addr[2] = 32'h0000_2000; req_len[2] = 4'd7;
    rsp_ready = 4'b1011; toggle_en = 1'b1;
    req_cnt[2] = 1;
    wait_done("t3");
    toggle_en = 1'b0; rsp_ready = '1;
    chk("t3_nbeats", beat_q.size(), 8);
    foreach (beat_q[i]) begin
      chk("t3_who", beat_q[i].who, 2);
      chk("t3_beatno", beat_q[i].data[31:0], i);
      chk("t3_addr_tag", beat_q[i].data[127:96], 32'h2000);
      chk("t3_last", beat_q[i].last, i == 7);
    end

    // SLVERR on the second beat
    clear_logs();
    req_addr[1] = 32'h0000_3008; req_len[1] = 4'd3; err_beat = 1;
    req_cnt[1] = 1;
    wait_done("t4");
    err_beat = -1;
    chk("t4_araddr", ar_addr_cap, 32'h0000_3000);
    chk("t4_nbeats", beat_q.size(), 4);
    foreach (beat_q[i]) begin
      chk("t4_who", beat_q[i].who, 1);
      chk("t4_err", beat_q[i].err, i == 1);
      chk("t4_last", beat_q[i].last, i == 3);
    end

    // reset in the middle of a 16-beat burst
    clear_logs();
    req_addr[3] = 32'h0000_4000; req_len[3] = 4'd15;
    req_cnt[3] = 1;
    n = 0;
    while (beat_q.size() < 1 && n < 100) begin cyc(); n++; end
    chk("t5_burst_started", beat_q.size() >= 1, 1'b1);
    reset = 1'b1;
    req_cnt[3] = 0;
    cyc();
    @(negedge clk);
    chk("t5_arvalid", arvalidm_a, 1'b0);
    chk("t5_rready", rreadym_a, 1'b0);
    chk("t5_rsp_valid", rsp_valid, 4'b0000);
    chk("t5_state", dut.state, ARB_IDLE);
    cyc();
    reset = 1'b0;
    clear_logs();
    req_addr[0] = 32'h0000_5100; req_len[0] = 4'd0;
    req_addr[2] = 32'h0000_5200; req_len[2] = 4'd0;
    req_cnt[0] = 1; req_cnt[2] = 1;
    wait_done("t5b");
    chk("t5_ngrants", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("t5_first_grant", grant_q[0], 0);
      chk("t5_second_grant", grant_q[1], 2);
    end

    // early rlast on beat 2 of a 4-beat burst
    clear_logs();
    req_addr[0] = 32'h0000_6000; req_len[0] = 4'd3; early_last = 1;
    req_cnt[0] = 1;
    wait_done("t6");
    early_last = 99;
    chk("t6_nbeats", beat_q.size(), 2);
    if (beat_q.size() == 2) chk("t6_last", beat_q[1].last, 1'b1);
    chk("t6_mismatch", dut.len_mismatch, 1'b1);
    clear_logs();
    req_addr[1] = 32'h0000_7000; req_len[1] = 4'd0;
    req_addr[3] = 32'h0000_7100; req_len[3] = 4'd1;
    req_cnt[1] = 1; req_cnt[3] = 1;
    wait_done("t6b");
    chk("t6b_ngrants", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("t6b_grant0", grant_q[0], 1);
      chk("t6b_grant1", grant_q[1], 3);
    end
    chk("t6b_nbeats", beat_q.size(), 3);
    chk("t6b_mismatch_sticky", dut.len_mismatch, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
